// File: rtl/cpu_defs_pkg.sv
// Shared multi-cycle CPU definitions: opcodes, functs, control FSM state encoding,
// ALU operation codes and ALU operand select codes.
package cpu_defs_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [3:0] {
    S_IF       = 4'd0,
    S_ID       = 4'd1,
    S_EXE_R    = 4'd2,
    S_EXE_I    = 4'd3,
    S_EXE_ADDR = 4'd4,
    S_MEM_RD   = 4'd5,
    S_MEM_WR   = 4'd6,
    S_WB_ALU   = 4'd7,
    S_WB_MEM   = 4'd8,
    S_BR       = 4'd9,
    S_JMP      = 4'd10,
    S_HALT     = 4'd11
  } state_e;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_SLT = 3'd4
  } alu_op_e;

  localparam logic [1:0] SRCA_PC   = 2'd0;
  localparam logic [1:0] SRCA_RS   = 2'd1;
  localparam logic [1:0] SRCA_ZERO = 2'd2;

  localparam logic [1:0] SRCB_RT      = 2'd0;
  localparam logic [1:0] SRCB_IMM     = 2'd1;
  localparam logic [1:0] SRCB_BR_OFS  = 2'd2;
  localparam logic [1:0] SRCB_JTARGET = 2'd3;

  function automatic logic funct_is_legal(input logic [5:0] funct);
    case (funct)
      FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: return 1'b1;
      default:                               return 1'b0;
    endcase
  endfunction

  function automatic alu_op_e funct_to_alu_op(input logic [5:0] funct);
    case (funct)
      FN_ADD:  return ALU_ADD;
      FN_SUB:  return ALU_SUB;
      FN_AND:  return ALU_AND;
      FN_OR:   return ALU_OR;
      FN_SLT:  return ALU_SLT;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_ctrl_fsm_alu_op_decode.sv
// ALU operation and immediate-extension decode for the multi-cycle control FSM.
module alu_op_decode
  import cpu_defs_pkg::*;
(
  input  state_e     state_i,
  input  logic [5:0] opcode_i,
  input  logic [5:0] funct_i,
  output logic [2:0] alu_op_o,
  output logic       ext_sel_o
);

  // ALU op / extension select per state; ID precomputes the branch target with a signed offset
  always_comb begin
    alu_op_o  = ALU_ADD;
    ext_sel_o = 1'b0;
    case (state_i)
      S_ID, S_EXE_ADDR: begin
        alu_op_o  = ALU_ADD;
        ext_sel_o = 1'b1;
      end
      S_EXE_R: begin
        alu_op_o  = funct_to_alu_op(funct_i);
        ext_sel_o = 1'b0;
      end
      S_EXE_I: begin
        if (opcode_i == OP_ORI) begin
          alu_op_o  = ALU_OR;
          ext_sel_o = 1'b0;
        end else begin
          alu_op_o  = ALU_ADD;
          ext_sel_o = 1'b1;
        end
      end
      S_BR: begin
        alu_op_o  = ALU_SUB;
        ext_sel_o = 1'b0;
      end
      default: begin
        alu_op_o  = ALU_ADD;
        ext_sel_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Main control FSM of the multi-cycle CPU: sequences IF/ID/EXE/MEM/WB and drives
// the PC write enable, PC source select and every datapath enable.
module multicycle_ctrl_fsm
  import cpu_defs_pkg::*;
#(
  parameter logic [5:0]  HALT_OP = 6'b111111,
  parameter int unsigned STATE_W = 4
)(
  input  logic               CLK,
  input  logic               Reset,
  input  logic [5:0]         Opcode,
  input  logic [5:0]         Funct,
  input  logic               Zero,
  output logic               PCWr,
  output logic               PCSrc,
  output logic               IRWr,
  output logic               MemRd,
  output logic               MemWr,
  output logic               RegWr,
  output logic               RegDst,
  output logic               MemToReg,
  output logic [1:0]         ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic               ExtSel,
  output logic [2:0]         ALUOp,
  output logic [STATE_W-1:0] State
);

  state_e state_q;
  state_e state_d;

  assign State = STATE_W'(state_q);

  // State register; Reset forces IF immediately so outputs take fetch values at once
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q <= S_IF;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode
  always_comb begin
    state_d = S_IF;
    case (state_q)
      S_IF: state_d = S_ID;
      S_ID: begin
        if (Opcode == HALT_OP) begin
          state_d = S_HALT;
        end else begin
          case (Opcode)
            OP_RTYPE:        state_d = funct_is_legal(Funct) ? S_EXE_R : S_IF;
            OP_ADDI, OP_ORI: state_d = S_EXE_I;
            OP_LW, OP_SW:    state_d = S_EXE_ADDR;
            OP_BEQ, OP_BNE:  state_d = S_BR;
            OP_J:            state_d = S_JMP;
            default:         state_d = S_IF;
          endcase
        end
      end
      S_EXE_R:    state_d = S_WB_ALU;
      S_EXE_I:    state_d = S_WB_ALU;
      S_EXE_ADDR: begin
        if (Opcode == OP_SW) begin
          state_d = S_MEM_WR;
        end else begin
          state_d = S_MEM_RD;
        end
      end
      S_MEM_RD: state_d = S_WB_MEM;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_IF;
    endcase
  end

  // Moore output decode; only PCWr in BR looks at Zero
  always_comb begin
    PCWr     = 1'b0;
    PCSrc    = 1'b0;
    IRWr     = 1'b0;
    MemRd    = 1'b0;
    MemWr    = 1'b0;
    RegWr    = 1'b0;
    RegDst   = 1'b0;
    MemToReg = 1'b0;
    ALUSrcA  = SRCA_PC;
    ALUSrcB  = SRCB_RT;
    case (state_q)
      S_IF: begin
        IRWr = 1'b1;
        PCWr = 1'b1;
      end
      S_ID: begin
        if (Opcode == OP_J) begin
          ALUSrcA = SRCA_ZERO;
          ALUSrcB = SRCB_JTARGET;
        end else begin
          ALUSrcA = SRCA_PC;
          ALUSrcB = SRCB_BR_OFS;
        end
      end
      S_EXE_R: begin
        ALUSrcA = SRCA_RS;
        ALUSrcB = SRCB_RT;
      end
      S_EXE_I, S_EXE_ADDR: begin
        ALUSrcA = SRCA_RS;
        ALUSrcB = SRCB_IMM;
      end
      S_MEM_RD: MemRd = 1'b1;
      S_MEM_WR: MemWr = 1'b1;
      S_WB_ALU: begin
        RegWr  = 1'b1;
        RegDst = (Opcode == OP_RTYPE);
      end
      S_WB_MEM: begin
        RegWr    = 1'b1;
        MemToReg = 1'b1;
      end
      S_BR: begin
        ALUSrcA = SRCA_RS;
        ALUSrcB = SRCB_RT;
        PCSrc   = 1'b1;
        if (Opcode == OP_BEQ) begin
          PCWr = Zero;
        end else if (Opcode == OP_BNE) begin
          PCWr = ~Zero;
        end else begin
          PCWr = 1'b0;
        end
      end
      S_JMP: begin
        PCWr  = 1'b1;
        PCSrc = 1'b1;
      end
      default: begin
        PCWr = 1'b0;
      end
    endcase
  end

  alu_op_decode u_alu_op_decode (
    .state_i   (state_q),
    .opcode_i  (Opcode),
    .funct_i   (Funct),
    .alu_op_o  (ALUOp),
    .ext_sel_o (ExtSel)
  );

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Scoreboard bench for multicycle_ctrl_fsm: an instruction-level model queues the
// expected per-cycle control word, a negedge monitor compares it against the DUT.
`timescale 1ns/1ps
module tb_multicycle_ctrl_fsm;

  typedef struct packed {
    logic [3:0] st;
    logic       pcwr;
    logic       pcsrc;
    logic       irwr;
    logic       memrd;
    logic       memwr;
    logic       regwr;
    logic       regdst;
    logic       memtoreg;
    logic [1:0] srca;
    logic [1:0] srcb;
    logic       extsel;
    logic [2:0] aluop;
  } rec_t;

  logic       CLK = 1'b0;
  logic       Reset;
  logic [5:0] Opcode;
  logic [5:0] Funct;
  logic       Zero;
  logic       PCWr, PCSrc, IRWr, MemRd, MemWr, RegWr, RegDst, MemToReg, ExtSel;
  logic [1:0] ALUSrcA, ALUSrcB;
  logic [2:0] ALUOp;
  logic [3:0] State;

  rec_t exp_q[$];
  rec_t mon_e;
  int   total = 0;
  int   bad   = 0;

  always #5 CLK = ~CLK;

  multicycle_ctrl_fsm #(.HALT_OP(6'h3F), .STATE_W(4)) dut (
    .CLK(CLK), .Reset(Reset), .Opcode(Opcode), .Funct(Funct), .Zero(Zero),
    .PCWr(PCWr), .PCSrc(PCSrc), .IRWr(IRWr), .MemRd(MemRd), .MemWr(MemWr),
    .RegWr(RegWr), .RegDst(RegDst), .MemToReg(MemToReg), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ExtSel(ExtSel), .ALUOp(ALUOp), .State(State)
  );

  function automatic rec_t cur();
    rec_t r;
    r.st = State;     r.pcwr = PCWr;     r.pcsrc = PCSrc;   r.irwr = IRWr;
    r.memrd = MemRd;  r.memwr = MemWr;   r.regwr = RegWr;   r.regdst = RegDst;
    r.memtoreg = MemToReg; r.srca = ALUSrcA; r.srcb = ALUSrcB;
    r.extsel = ExtSel; r.aluop = ALUOp;
    return r;
  endfunction

  function automatic rec_t mk(input logic [3:0] st);
    rec_t r;
    r = '0;
    r.st = st;
    return r;
  endfunction

  function automatic rec_t fetch_rec();
    rec_t r;
    r = mk(4'd0);
    r.pcwr = 1'b1;
    r.irwr = 1'b1;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", name, got, want);
    end
  endtask

  // Instruction-level reference: list of phases each instruction walks through
  task automatic push_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                            input bit skip_fetch, output int n);
    rec_t r;
    int   start;
    bit   r_legal;
    start   = exp_q.size();
    r_legal = (op == 6'h00) && (fn == 6'h20 || fn == 6'h22 || fn == 6'h24 ||
                                fn == 6'h25 || fn == 6'h2A);
    if (!skip_fetch) exp_q.push_back(fetch_rec());
    r = mk(4'd1); r.srcb = 2'd2; r.extsel = 1'b1;
    if (op == 6'h02) begin r.srca = 2'd2; r.srcb = 2'd3; end
    exp_q.push_back(r);
    if (op == 6'h3F) begin
      repeat (20) exp_q.push_back(mk(4'd11));
    end else if (r_legal) begin
      r = mk(4'd2); r.srca = 2'd1;
      case (fn)
        6'h20:   r.aluop = 3'd0;
        6'h22:   r.aluop = 3'd1;
        6'h24:   r.aluop = 3'd2;
        6'h25:   r.aluop = 3'd3;
        default: r.aluop = 3'd4;
      endcase
      exp_q.push_back(r);
      r = mk(4'd7); r.regwr = 1'b1; r.regdst = 1'b1;
      exp_q.push_back(r);
    end else if (op == 6'h08 || op == 6'h0D) begin
      r = mk(4'd3); r.srca = 2'd1; r.srcb = 2'd1;
      r.extsel = (op == 6'h08);
      r.aluop  = (op == 6'h08) ? 3'd0 : 3'd3;
      exp_q.push_back(r);
      r = mk(4'd7); r.regwr = 1'b1;
      exp_q.push_back(r);
    end else if (op == 6'h23 || op == 6'h2B) begin
      r = mk(4'd4); r.srca = 2'd1; r.srcb = 2'd1; r.extsel = 1'b1;
      exp_q.push_back(r);
      if (op == 6'h23) begin
        r = mk(4'd5); r.memrd = 1'b1; exp_q.push_back(r);
        r = mk(4'd8); r.regwr = 1'b1; r.memtoreg = 1'b1; exp_q.push_back(r);
      end else begin
        r = mk(4'd6); r.memwr = 1'b1; exp_q.push_back(r);
      end
    end else if (op == 6'h04 || op == 6'h05) begin
      r = mk(4'd9); r.srca = 2'd1; r.aluop = 3'd1; r.pcsrc = 1'b1;
      r.pcwr = (op == 6'h04) ? z : ~z;
      exp_q.push_back(r);
    end else if (op == 6'h02) begin
      r = mk(4'd10); r.pcwr = 1'b1; r.pcsrc = 1'b1;
      exp_q.push_back(r);
    end
    n = exp_q.size() - start;
  endtask

  // Entered at posedge+1 with the DUT in IF; leaves it the same way
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z);
    int n;
    Opcode = op; Funct = fn; Zero = z;
    push_instr(op, fn, z, 1'b0, n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // 3 ns Reset pulse after the current negedge, then realign on an illegal opcode
  task automatic reset_mid();
    int n;
    @(negedge CLK); #1;
    Reset = 1'b1;
    #1;
    check("async_reset_outputs", {12'd0, cur()}, {12'd0, fetch_rec()});
    Opcode = 6'h3E; Funct = 6'h00;
    #2;
    Reset = 1'b0;
    @(posedge CLK); #1;
    check("post_reset_to_ID", {28'd0, State}, 32'd1);
    push_instr(6'h3E, 6'h00, 1'b0, 1'b1, n);
    @(posedge CLK); #1;
  endtask

  // Scoreboard monitor
  always @(negedge CLK) begin
    if (!Reset && exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check($sformatf("cycle_state%0d", mon_e.st), {12'd0, cur()}, {12'd0, mon_e});
    end
  end

  initial begin
    logic [5:0] ops[9];
    logic [5:0] fns[6];
    logic [5:0] op;
    logic [5:0] fn;
    int n;
    ops = '{6'h00, 6'h08, 6'h0D, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h00};
    fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h00};

    Reset = 1'b1; Opcode = 6'h00; Funct = 6'h00; Zero = 1'b0;
    #3;
    check("reset_state", {12'd0, cur()}, {12'd0, fetch_rec()});
    repeat (2) @(posedge CLK);
    #1;
    Reset = 1'b0;

    run_instr(6'h00, 6'h20, 1'b0);
    run_instr(6'h23, 6'h00, 1'b0);
    run_instr(6'h2B, 6'h00, 1'b0);
    run_instr(6'h04, 6'h00, 1'b1);
    run_instr(6'h04, 6'h00, 1'b0);
    run_instr(6'h05, 6'h00, 1'b0);
    run_instr(6'h05, 6'h00, 1'b1);
    run_instr(6'h02, 6'h00, 1'b0);
    run_instr(6'h3E, 6'h00, 1'b0);
    run_instr(6'h00, 6'h22, 1'b1);
    run_instr(6'h00, 6'h24, 1'b0);
    run_instr(6'h00, 6'h25, 1'b0);
    run_instr(6'h00, 6'h2A, 1'b0);
    run_instr(6'h00, 6'h21, 1'b0);
    run_instr(6'h08, 6'h00, 1'b0);
    run_instr(6'h0D, 6'h00, 1'b0);

    // Reset during WB_MEM of a lw
    Opcode = 6'h23; Funct = 6'h00; Zero = 1'b0;
    push_instr(6'h23, 6'h00, 1'b0, 1'b0, n);
    repeat (n - 1) @(posedge CLK);
    #1;
    reset_mid();

    for (int i = 0; i < 150; i++) begin
      op = ops[$urandom_range(0, 8)];
      if ($urandom_range(0, 7) == 0) op = 6'($urandom_range(0, 62));
      fn = (op == 6'h00) ? fns[$urandom_range(0, 5)] : 6'($urandom_range(0, 63));
      if (fn == 6'h00 && op == 6'h00) fn = 6'($urandom_range(0, 63));
      run_instr(op, fn, 1'($urandom_range(0, 1)));
    end

    // HALT holds for 20 cycles, then Reset releases it
    Opcode = 6'h3F; Funct = 6'h00; Zero = 1'b1;
    push_instr(6'h3F, 6'h00, 1'b1, 1'b0, n);
    repeat (n - 1) @(posedge CLK);
    #1;
    reset_mid();

    run_instr(6'h00, 6'h20, 1'b0);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
